// File: rtl/tohost_pkg.sv
// tohost_pkg: shared status encoding and default addresses for the tohost responder
//   status_e          : RUN=0 PASS=1 FAIL=2 PCHALT=3 TIMEOUT=4
//   TOHOST_ADDR_DEF   : byte address whose stores report the test result
//   CONSOLE_ADDR_DEF  : byte address whose stores push a console byte
//   HALT_PC_DEF       : PC that ends the run (one past the 16-word ROM)
package tohost_pkg;
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_PCHALT  = 3'd3,
        ST_TIMEOUT = 3'd4
    } status_e;
    localparam logic [31:0] TOHOST_ADDR_DEF  = 32'h0000_0040;
    localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0000_0044;
    localparam logic [31:0] HALT_PC_DEF      = 32'd64;
endpackage

// File: rtl/tohost_cons_fifo.sv
// tohost_cons_fifo: synchronous FIFO with extra-bit pointers, head visible without latency
//   clk, rst_n     : clock, asynchronous active-low reset
//   push_i/data_i  : write request and byte; dropped when full unless popping
//   pop_i          : remove head entry (ignored when empty)
//   data_o         : head entry, zero when empty
//   full_o/empty_o : occupancy flags
module tohost_cons_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    logic [PW:0]  wr_q, rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // a simultaneous pop frees the slot the push is about to fill
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_q[PW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (PW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (PW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
    end
endmodule

// File: rtl/tohost_responder.sv
// tohost_responder: decodes core stores into a sticky pass/fail/halt status and a console FIFO
//   clk, reset          : clock, asynchronous active-low reset
//   MemWrite, DataAddr,
//   WriteData, PC       : core store port and program counter
//   halted, status,
//   fail_code           : registered run result (status != RUN ends the run)
//   cycle_count         : cycles spent in RUN, saturating
//   cons_valid/data/ready: console byte stream, cons_ovf sticky on dropped byte
// Optional watchdog: define TOHOST_WATCHDOG_EN to time out after WDOG_CYCLES cycles.
module tohost_responder
    import tohost_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR  = TOHOST_ADDR_DEF,
    parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
    parameter logic [31:0] HALT_PC      = HALT_PC_DEF,
    parameter int unsigned CONS_DEPTH   = 8
`ifdef TOHOST_WATCHDOG_EN
   ,parameter int unsigned WDOG_CYCLES  = 1024
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAddr,
    input  logic [31:0] WriteData,
    input  logic [31:0] PC,
    output logic        halted,
    output logic [2:0]  status,
    output logic [30:0] fail_code,
    output logic [31:0] cycle_count,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready,
    output logic        cons_ovf
);
`ifdef TOHOST_WATCHDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
`endif
    status_e     status_q;
    logic [30:0] fail_code_q;
    logic [31:0] cycle_q, cycle_d;
    logic        ovf_q;
    logic        tohost_wr, cons_push, cons_pop, cons_full, cons_empty;
    assign tohost_wr  = MemWrite && (DataAddr == TOHOST_ADDR);
    assign cons_push  = MemWrite && (DataAddr == CONSOLE_ADDR);
    assign cons_valid = !cons_empty;
    assign cons_pop   = cons_valid && cons_ready;
    assign cycle_d    = (&cycle_q) ? cycle_q : cycle_q + 32'd1;
    tohost_cons_fifo #(.DEPTH(CONS_DEPTH), .W(8)) u_cons (
        .clk    (clk),
        .rst_n  (reset),
        .push_i (cons_push),
        .pop_i  (cons_pop),
        .data_i (WriteData[7:0]),
        .data_o (cons_data),
        .full_o (cons_full),
        .empty_o(cons_empty)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q    <= ST_RUN;
            fail_code_q <= '0;
            cycle_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (cons_push && cons_full && !cons_pop) ovf_q <= 1'b1;
            if (status_q == ST_RUN) begin
                cycle_q <= cycle_d;
                // even tohost values are ignored and fall through to the lower-priority checks
                if (tohost_wr && WriteData == 32'd1) status_q <= ST_PASS;
                else if (tohost_wr && WriteData[0]) begin
                    status_q    <= ST_FAIL;
                    fail_code_q <= WriteData[31:1];
                end
                else if (PC == HALT_PC) status_q <= ST_PCHALT;
`ifdef TOHOST_WATCHDOG_EN
                else if (cycle_q == WDOG_LAST) status_q <= ST_TIMEOUT;
`endif
            end
        end
    end
    assign status      = status_q;
    assign halted      = status_q != ST_RUN;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_q;
    assign cons_ovf    = ovf_q;
endmodule

// File: tb/tb_tohost_responder.sv
// tb_tohost_responder: table vectors, directed corner sequences and random stimulus against a queue-based model
module tb_tohost_responder;
`ifdef TOHOST_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
    localparam int WD    = 16;
`else
    localparam bit WD_EN = 1'b0;
    localparam int WD    = 1024;
`endif
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAddr, WriteData, PC;
    logic        halted, cons_valid, cons_ready, cons_ovf;
    logic [2:0]  status;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;
    logic [7:0]  cons_data;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_st;
    logic [30:0] m_fc;
    logic [31:0] m_cyc;
    bit          m_ovf;
    logic [7:0]  m_q[$];

    typedef struct {
        logic        mw;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        rdy;
        logic [2:0]  st;
        logic [30:0] fc;
        logic [31:0] cyc;
        logic        cv;
        logic [7:0]  cd;
    } vec_t;
    vec_t tbl[7];

    tohost_responder #(
        .CONS_DEPTH(DEPTH)
`ifdef TOHOST_WATCHDOG_EN
       ,.WDOG_CYCLES(WD)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAddr   (DataAddr),
        .WriteData  (WriteData),
        .PC         (PC),
        .halted     (halted),
        .status     (status),
        .fail_code  (fail_code),
        .cycle_count(cycle_count),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .cons_ready (cons_ready),
        .cons_ovf   (cons_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".status"}, 32'(status), 32'(m_st));
        chk({tag, ".halted"}, 32'(halted), 32'(m_st != 0));
        chk({tag, ".fail_code"}, 32'(fail_code), 32'(m_fc));
        chk({tag, ".cycle_count"}, cycle_count, m_cyc);
        chk({tag, ".cons_valid"}, 32'(cons_valid), 32'(m_q.size() > 0));
        chk({tag, ".cons_data"}, 32'(cons_data), m_q.size() > 0 ? 32'(m_q[0]) : 32'd0);
        chk({tag, ".cons_ovf"}, 32'(cons_ovf), 32'(m_ovf));
    endtask

    task automatic set_in(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] pc, input logic rdy);
        MemWrite = mw; DataAddr = a; WriteData = wd; PC = pc; cons_ready = rdy;
    endtask

    // model advances from the inputs present before the edge, then DUT is compared after it
    task automatic tick(input string tag);
        bit pop, push, full, th;
        logic [31:0] old;
        pop  = m_q.size() > 0 && cons_ready;
        push = MemWrite && DataAddr == 32'h44;
        full = m_q.size() == DEPTH;
        th   = MemWrite && DataAddr == 32'h40;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (!full || pop) m_q.push_back(WriteData[7:0]);
            else m_ovf = 1'b1;
        end
        if (m_st == 0) begin
            old = m_cyc;
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (th && WriteData == 1) m_st = 1;
            else if (th && WriteData[0]) begin m_st = 2; m_fc = WriteData >> 1; end
            else if (PC == 64) m_st = 3;
            else if (WD_EN && old == 32'(WD - 1)) m_st = 4;
        end
        @(posedge clk);
        #1;
        cmp_model(tag);
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        m_st = 0; m_fc = '0; m_cyc = '0; m_ovf = 0; m_q.delete();
        #1;
        cmp_model("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tbl[0] = '{1'b1, 32'h44, 32'h48, 32'd0,  1'b0, 3'd0, 31'd0, 32'd1, 1'b1, 8'h48};
        tbl[1] = '{1'b1, 32'h44, 32'h69, 32'd4,  1'b0, 3'd0, 31'd0, 32'd2, 1'b1, 8'h48};
        tbl[2] = '{1'b1, 32'h40, 32'd6,  32'd8,  1'b0, 3'd0, 31'd0, 32'd3, 1'b1, 8'h48};
        tbl[3] = '{1'b1, 32'h50, 32'd1,  32'd12, 1'b1, 3'd0, 31'd0, 32'd4, 1'b1, 8'h69};
        tbl[4] = '{1'b1, 32'h40, 32'd7,  32'd16, 1'b1, 3'd2, 31'd3, 32'd5, 1'b0, 8'h00};
        tbl[5] = '{1'b1, 32'h40, 32'd1,  32'd20, 1'b0, 3'd2, 31'd3, 32'd5, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 32'h0,  32'd0,  32'd64, 1'b0, 3'd2, 31'd3, 32'd5, 1'b0, 8'h00};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(tbl[i].mw, tbl[i].addr, tbl[i].wd, tbl[i].pc, tbl[i].rdy);
            tick("tbl");
            chk($sformatf("tbl%0d.status", i), 32'(status), 32'(tbl[i].st));
            chk($sformatf("tbl%0d.fail_code", i), 32'(fail_code), 32'(tbl[i].fc));
            chk($sformatf("tbl%0d.cycle", i), cycle_count, tbl[i].cyc);
            chk($sformatf("tbl%0d.cons_valid", i), 32'(cons_valid), 32'(tbl[i].cv));
            chk($sformatf("tbl%0d.cons_data", i), 32'(cons_data), 32'(tbl[i].cd));
        end

        do_reset();
        for (int i = 0; i < 10; i++) tick("idle");
        set_in(1, 32'h40, 32'd1, 0, 0);
        tick("pass");
        chk("pass.status", 32'(status), 32'd1);
        chk("pass.halted", 32'(halted), 32'd1);
        chk("pass.cycle", cycle_count, 32'd11);
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("frozen");
        chk("frozen.cycle", cycle_count, 32'd11);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_in(1, 32'h44, 32'h10 + i, 0, 0);
            tick("fill");
        end
        chk("ovf.set", 32'(cons_ovf), 32'd1);
        chk("ovf.head", 32'(cons_data), 32'h10);
        set_in(1, 32'h44, 32'hAA, 0, 1);
        tick("fullpushpop");
        chk("fpp.head", 32'(cons_data), 32'h11);
        set_in(0, 0, 0, 0, 1);
        n = 0;
        while (cons_valid && n < 20) begin
            tick("drain");
            n++;
        end
        chk("drain.count", 32'(n), 32'd8);
        chk("drain.ovf_sticky", 32'(cons_ovf), 32'd1);

        do_reset();
        set_in(0, 0, 0, 64, 0);
        tick("pchalt");
        chk("pchalt.status", 32'(status), 32'd3);
        do_reset();
        set_in(1, 32'h40, 32'd1, 64, 0);
        tick("pass_vs_pc");
        chk("pass_vs_pc.status", 32'(status), 32'd1);

        do_reset();
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) tick("wdog");
        chk("wdog.pre", 32'(status), 32'd0);
        tick("wdog");
        chk("wdog.edge", 32'(status), WD_EN ? 32'd4 : 32'd0);
        chk("wdog.cycle", cycle_count, 32'd16);

        set_in(1, 32'h44, 32'h55, 0, 0);
        tick("pre_areset");
        do_reset();
        chk("areset.valid", 32'(cons_valid), 32'd0);
        chk("areset.status", 32'(status), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, wd;
            int k;
            if (i % 300 == 299) do_reset();
            k = $urandom_range(0, 9);
            a = k < 1 ? 32'h40 : k < 7 ? 32'h44 : $urandom;
            k = $urandom_range(0, 2);
            wd = k == 0 ? 32'd1 : k == 1 ? ($urandom | 32'd1) : ($urandom & ~32'd1);
            set_in($urandom_range(0, 99) < 40, a, wd,
                   $urandom_range(0, 99) == 0 ? 32'd64 : 32'($urandom_range(0, 15) * 4),
                   1'($urandom_range(0, 1)));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
